rvfi_commit_tracker: RTL

RVFI_COMMIT_TRACKER -- requirements
Module: rvfi_commit_tracker

---
 rtl/rvfi_commit_tracker.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rvfi_commit_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rvfi_commit_tracker                                          |
// | Description : Tracks in-flight instructions by tag and emits one RVFI      |
// |               retirement record per in-order commit. Optional halt         |
// |               detection is built when RVFI_HALT_DETECT_EN is defined.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rvfi_commit_tracker #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [TAG_W-1:0]  disp_tag,
  input  logic [31:0]       disp_inst,
  input  logic [31:0]       disp_pc,
  input  logic [31:0]       disp_pc_next,
  input  logic [4:0]        disp_rs1_addr,
  input  logic [4:0]        disp_rs2_addr,
  input  logic [4:0]        disp_rd_addr,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [31:0]       wb_rs1_rdata,
  input  logic [31:0]       wb_rs2_rdata,
  input  logic [31:0]       wb_rd_wdata,
  input  logic [31:0]       wb_pc_wdata,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_rmask,
  input  logic [3:0]        mem_wmask,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_inst,
  output logic [31:0]       rvfi_pc_rdata,
  output logic [31:0]       rvfi_pc_wdata,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [4:0]        rvfi_rd_addr,
  output logic [31:0]       rvfi_rs1_rdata,
  output logic [31:0]       rvfi_rs2_rdata,
  output logic [31:0]       rvfi_rd_wdata,
  output logic [31:0]       rvfi_mem_addr,
  output logic [31:0]       rvfi_mem_rdata,
  output logic [31:0]       rvfi_mem_wdata,
  output logic [3:0]        rvfi_mem_rmask,
  output logic [3:0]        rvfi_mem_wmask,
  output logic              error
`ifdef RVFI_HALT_DETECT_EN
  ,
  output logic              halt
`endif
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
  } entry_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  entry_t           ent_q [DEPTH];
  entry_t           out_q;
  logic             valid_q;
  logic [63:0]      order_q;
  logic [63:0]      cnt_q;
  logic             error_q;

  logic   w_disp_ok, w_wb_ok, w_mem_ok, w_cmt_ok, w_err;
  entry_t w_disp_rec;
  entry_t w_cmt_rec;

  // Updates coinciding with a flush are discarded; updates to idle entries are dropped.
  assign w_disp_ok = disp_valid && !flush;
  assign w_wb_ok   = wb_valid  && !flush && busy_q[wb_tag];
  assign w_mem_ok  = mem_valid && !flush && busy_q[mem_tag];
  assign w_cmt_ok  = commit_valid && busy_q[commit_tag];

  // Dispatch onto the entry retiring this same cycle is a legal reuse, not a collision.
  assign w_err = (w_disp_ok && busy_q[disp_tag] && !(w_cmt_ok && (commit_tag == disp_tag)))
               || (wb_valid  && !flush && !busy_q[wb_tag])
               || (mem_valid && !flush && !busy_q[mem_tag])
               || (commit_valid && !busy_q[commit_tag]);

  // Fresh entry image for dispatch: result and memory fields start at zero.
  always_comb begin
    w_disp_rec           = '0;
    w_disp_rec.inst      = disp_inst;
    w_disp_rec.pc_rdata  = disp_pc;
    w_disp_rec.pc_wdata  = disp_pc_next;
    w_disp_rec.rs1_addr  = disp_rs1_addr;
    w_disp_rec.rs2_addr  = disp_rs2_addr;
    w_disp_rec.rd_addr   = disp_rd_addr;
  end

  // Retirement record: stored entry, overlaid with same-cycle wb/mem data, x0 reads/writes zeroed.
  always_comb begin
    w_cmt_rec = ent_q[commit_tag];
    if (w_wb_ok && (wb_tag == commit_tag)) begin
      w_cmt_rec.rs1_rdata = wb_rs1_rdata;
      w_cmt_rec.rs2_rdata = wb_rs2_rdata;
      w_cmt_rec.rd_wdata  = wb_rd_wdata;
      w_cmt_rec.pc_wdata  = wb_pc_wdata;
    end
    if (w_mem_ok && (mem_tag == commit_tag)) begin
      w_cmt_rec.mem_addr  = mem_addr;
      w_cmt_rec.mem_rdata = mem_rdata;
      w_cmt_rec.mem_wdata = mem_wdata;
      w_cmt_rec.mem_rmask = mem_rmask;
      w_cmt_rec.mem_wmask = mem_wmask;
    end
    if (w_cmt_rec.rd_addr == 5'd0) begin
      w_cmt_rec.rd_wdata = '0;
    end
    if (w_cmt_rec.rs1_addr == 5'd0) begin
      w_cmt_rec.rs1_rdata = '0;
    end
    if (w_cmt_rec.rs2_addr == 5'd0) begin
      w_cmt_rec.rs2_rdata = '0;
    end
  end

  // Busy next state: commit frees first so a same-tag dispatch re-arms the entry.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (w_cmt_ok) begin
        busy_d[commit_tag] = 1'b0;
      end
      if (w_disp_ok) begin
        busy_d[disp_tag] = 1'b1;
      end
    end
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Entry payload storage; contents are meaningless while the busy bit is clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_disp_ok) begin
        ent_q[disp_tag] <= w_disp_rec;
      end
      if (w_wb_ok) begin
        ent_q[wb_tag].rs1_rdata <= wb_rs1_rdata;
        ent_q[wb_tag].rs2_rdata <= wb_rs2_rdata;
        ent_q[wb_tag].rd_wdata  <= wb_rd_wdata;
        ent_q[wb_tag].pc_wdata  <= wb_pc_wdata;
      end
      if (w_mem_ok) begin
        ent_q[mem_tag].mem_addr  <= mem_addr;
        ent_q[mem_tag].mem_rdata <= mem_rdata;
        ent_q[mem_tag].mem_wdata <= mem_wdata;
        ent_q[mem_tag].mem_rmask <= mem_rmask;
        ent_q[mem_tag].mem_wmask <= mem_wmask;
      end
    end
  end

  // Retirement output register: one-cycle strobe, record held until the next retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      order_q <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      valid_q <= w_cmt_ok;
      if (w_cmt_ok) begin
        out_q   <= w_cmt_rec;
        order_q <= cnt_q;
        cnt_q   <= cnt_q + 64'd1;
      end
      if (w_err) begin
        error_q <= 1'b1;
      end
    end
  end

`ifdef RVFI_HALT_DETECT_EN
  logic halt_q;

  // Sticky halt on a self-loop: next PC equals PC, or beq x0,x0,0 / jal x0,0 encodings.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (w_cmt_ok && ((w_cmt_rec.pc_rdata == w_cmt_rec.pc_wdata) ||
                              (w_cmt_rec.inst == 32'h0000_0063) ||
                              (w_cmt_rec.inst == 32'h0000_006f))) begin
      halt_q <= 1'b1;
    end
  end

  assign halt = halt_q;
`endif

  assign rvfi_valid     = valid_q;
  assign rvfi_order     = order_q;
  assign rvfi_inst      = out_q.inst;
  assign rvfi_pc_rdata  = out_q.pc_rdata;
  assign rvfi_pc_wdata  = out_q.pc_wdata;
  assign rvfi_rs1_addr  = out_q.rs1_addr;
  assign rvfi_rs2_addr  = out_q.rs2_addr;
  assign rvfi_rd_addr   = out_q.rd_addr;
  assign rvfi_rs1_rdata = out_q.rs1_rdata;
  assign rvfi_rs2_rdata = out_q.rs2_rdata;
  assign rvfi_rd_wdata  = out_q.rd_wdata;
  assign rvfi_mem_addr  = out_q.mem_addr;
  assign rvfi_mem_rdata = out_q.mem_rdata;
  assign rvfi_mem_wdata = out_q.mem_wdata;
  assign rvfi_mem_rmask = out_q.mem_rmask;
  assign rvfi_mem_wmask = out_q.mem_wmask;
  assign error          = error_q;

endmodule
`default_nettype wire
